// File: rtl/id_queue.sv
// id_queue: decode queue with RAW scoreboard and control-flow issue blocking.
// Define ID_WB_BYPASS_EN to forward writeback data to a head stalled on that register.
module id_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [XLEN-1:0]          if_pc_i,
  input  logic [31:0]              if_inst_i,
  output logic [4:0]               reg1_addr_o,
  output logic [4:0]               reg2_addr_o,
  input  logic [XLEN-1:0]          reg1_data_i,
  input  logic [XLEN-1:0]          reg2_data_i,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  output logic [XLEN-1:0]          pc_o,
  output logic [6:0]               aluop_o,
  output logic [2:0]               alufunct3_o,
  output logic [6:0]               alufunct7_o,
  output logic [XLEN-1:0]          reg1_o,
  output logic [XLEN-1:0]          reg2_o,
  output logic [XLEN-1:0]          imm_o,
  output logic                     wreg_o,
  output logic [4:0]               wd_o,
  input  logic                     wb_we_i,
  input  logic [4:0]               wb_addr_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic                     resolve_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_ST = 7'h23, OP_R = 7'h33;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            cf_q, cf_d, ex_valid_q, ex_valid_d, wreg_q, wreg_d;
  logic [XLEN-1:0] pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
  logic [6:0]      aluop_q, aluop_d, funct7_q, funct7_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      wd_q, wd_d, rs1, rs2, rd;
  logic [31:0]     inst, imm32;
  logic [6:0]      opc;
  logic            empty, full, push, issue, t_u, t_j, t_b, t_s, t_r;
  logic            use1, use2, wreg, is_cf, byp1, byp2, rdy1, rdy2;
  always_comb begin
    empty = count_q == '0;
    full = count_q == (AW+1)'(DEPTH);
    if_ready_o = !full && !flush_i;
    push = if_valid_i && if_ready_o;
    inst = empty ? 32'h0 : inst_mem[rptr_q];
    opc = inst[6:0];
    rs1 = inst[19:15];
    rs2 = inst[24:20];
    rd = inst[11:7];
    t_u = opc == OP_LUI || opc == OP_AUIPC;
    t_j = opc == OP_JAL;
    t_b = opc == OP_BR;
    t_s = opc == OP_ST;
    t_r = opc == OP_R;
    use1 = !t_u && !t_j;
    use2 = t_r || t_s || t_b;
    wreg = !t_b && !t_s;
    is_cf = t_j || t_b || opc == OP_JALR;
    imm32 = t_u ? {inst[31:12], 12'h0} :
            t_j ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
            t_b ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
            t_s ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
            t_r ? 32'h0 : {{20{inst[31]}}, inst[31:20]};
`ifdef ID_WB_BYPASS_EN
    byp1 = wb_we_i && wb_addr_i == rs1 && busy_q[rs1];
    byp2 = wb_we_i && wb_addr_i == rs2 && busy_q[rs2];
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    rdy1 = !busy_q[rs1] || byp1;
    rdy2 = !busy_q[rs2] || byp2;
    issue = !empty && (!ex_valid_q || ex_ready_i) && (!use1 || rdy1) && (!use2 || rdy2) &&
            !cf_q && !flush_i;
    wptr_d = flush_i ? '0 : wptr_q + AW'(push);
    rptr_d = flush_i ? '0 : rptr_q + AW'(issue);
    count_d = flush_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(issue);
    // clear first so a same-cycle set on the same register wins
    busy_d = busy_q;
    if (wb_we_i) busy_d[wb_addr_i] = 1'b0;
    if (issue && wreg) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
    cf_d = flush_i ? 1'b0 : (issue && is_cf) ? 1'b1 : resolve_i ? 1'b0 : cf_q;
    ex_valid_d = issue || (ex_valid_q && !ex_ready_i);
    pc_d = issue ? pc_mem[rptr_q] : pc_q;
    aluop_d = issue ? opc : aluop_q;
    funct3_d = issue ? inst[14:12] : funct3_q;
    funct7_d = issue ? inst[31:25] : funct7_q;
    imm_d = issue ? XLEN'($signed(imm32)) : imm_q;
    reg1_d = !issue ? reg1_q : use1 ? (byp1 ? wb_data_i : reg1_data_i) : XLEN'($signed(imm32));
    reg2_d = !issue ? reg2_q : use2 ? (byp2 ? wb_data_i : reg2_data_i) : XLEN'($signed(imm32));
    wreg_d = issue ? wreg : wreg_q;
    wd_d = issue ? rd : wd_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q] <= if_pc_i;
      inst_mem[wptr_q] <= if_inst_i;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      busy_q <= '0;
      cf_q <= 1'b0;
      ex_valid_q <= 1'b0;
      pc_q <= '0;
      aluop_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm_q <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
      wreg_q <= 1'b0;
      wd_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      busy_q <= busy_d;
      cf_q <= cf_d;
      ex_valid_q <= ex_valid_d;
      pc_q <= pc_d;
      aluop_q <= aluop_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      imm_q <= imm_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      wreg_q <= wreg_d;
      wd_q <= wd_d;
    end
  end
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;
  assign ex_valid_o = ex_valid_q;
  assign pc_o = pc_q;
  assign aluop_o = aluop_q;
  assign alufunct3_o = funct3_q;
  assign alufunct7_o = funct7_q;
  assign reg1_o = reg1_q;
  assign reg2_o = reg2_q;
  assign imm_o = imm_q;
  assign wreg_o = wreg_q;
  assign wd_o = wd_q;
  assign count_o = count_q;
endmodule

// File: tb/tb_id_queue.sv
// tb_id_queue: random and directed stimulus for id_queue against a queue-based reference model.
module tb_id_queue;
  localparam int XLEN = 32, DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic if_valid_i, if_ready_o, ex_valid_o, ex_ready_i, wreg_o, wb_we_i, resolve_i, flush_i;
  logic [31:0] if_pc_i, if_inst_i, reg1_data_i, reg2_data_i, pc_o, reg1_o, reg2_o, imm_o, wb_data_i;
  logic [4:0] reg1_addr_o, reg2_addr_o, wd_o, wb_addr_i;
  logic [6:0] aluop_o, alufunct7_o;
  logic [2:0] alufunct3_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [31:0] rf [32];
  always_comb begin
    reg1_data_i = rf[reg1_addr_o];
    reg2_data_i = rf[reg2_addr_o];
  end
  id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_pc_i(if_pc_i),
    .if_inst_i(if_inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i), .pc_o(pc_o), .aluop_o(aluop_o), .alufunct3_o(alufunct3_o),
    .alufunct7_o(alufunct7_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o), .wreg_o(wreg_o),
    .wd_o(wd_o), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .resolve_i(resolve_i), .flush_i(flush_i), .count_o(count_o));
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];
  bit [31:0] busy;
  bit cf, exv, e_wr;
  logic [31:0] e_pc, e_r1, e_r2, e_imm;
  logic [6:0] e_op, e_f7;
  logic [2:0] e_f3;
  logic [4:0] e_wd;
  function automatic void dec(input logic [31:0] i, output logic [31:0] imm,
                              output bit u1, output bit u2, output bit wr, output bit c);
    u1 = 1; u2 = 0; wr = 1; c = 0;
    imm = {{21{i[31]}}, i[30:20]};
    case (i[6:0])
      7'h37, 7'h17: begin imm = {i[31:12], 12'h0}; u1 = 0; end
      7'h6f: begin imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; u1 = 0; c = 1; end
      7'h63: begin imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; u2 = 1; wr = 0; c = 1; end
      7'h23: begin imm = {{21{i[31]}}, i[30:25], i[11:7]}; u2 = 1; wr = 0; end
      7'h33: begin imm = 0; u2 = 1; end
      7'h67: c = 1;
      default: ;
    endcase
  endfunction
  function automatic bit byp(input bit we, input logic [4:0] wa, input logic [4:0] r);
`ifdef ID_WB_BYPASS_EN
    return we && wa == r && busy[r];
`else
    return 0;
`endif
  endfunction
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit rdy,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit res, input bit fl);
    ent_t h;
    logic [31:0] imm;
    logic [4:0] s1, s2, rd;
    bit u1, u2, wr, c, iss, push;
    @(negedge clk);
    if_valid_i = v; if_pc_i = pc; if_inst_i = inst; ex_ready_i = rdy;
    wb_we_i = we; wb_addr_i = wa; wb_data_i = wd; resolve_i = res; flush_i = fl;
    #1;
    chk("count", count_o, q.size());
    chk("if_ready", if_ready_o, q.size() < DEPTH && !fl);
    chk("ex_valid", ex_valid_o, exv);
    chk("pc", pc_o, e_pc);
    chk("aluop", aluop_o, e_op);
    chk("funct3", alufunct3_o, e_f3);
    chk("funct7", alufunct7_o, e_f7);
    chk("reg1", reg1_o, e_r1);
    chk("reg2", reg2_o, e_r2);
    chk("imm", imm_o, e_imm);
    chk("wreg", wreg_o, e_wr);
    chk("wd", wd_o, e_wd);
    chk("rs1_addr", reg1_addr_o, q.size() > 0 ? q[0].inst[19:15] : 5'd0);
    push = v && q.size() < DEPTH && !fl;
    iss = 0;
    if (q.size() > 0) begin
      h = q[0];
      dec(h.inst, imm, u1, u2, wr, c);
      s1 = h.inst[19:15]; s2 = h.inst[24:20]; rd = h.inst[11:7];
      iss = (!exv || rdy) && !cf && !fl && !(u1 && busy[s1] && !byp(we, wa, s1)) &&
            !(u2 && busy[s2] && !byp(we, wa, s2));
      if (iss) begin
        e_pc = h.pc; e_op = h.inst[6:0]; e_f3 = h.inst[14:12]; e_f7 = h.inst[31:25];
        e_imm = imm; e_wr = wr; e_wd = rd;
        e_r1 = !u1 ? imm : byp(we, wa, s1) ? wd : rf[s1];
        e_r2 = !u2 ? imm : byp(we, wa, s2) ? wd : rf[s2];
      end
    end
    exv = iss || (exv && !rdy);
    if (we && wa != 0) busy[wa] = 0;
    if (iss && wr && rd != 0) busy[rd] = 1;
    cf = fl ? 0 : (iss && c) ? 1 : res ? 0 : cf;
    if (fl) q.delete();
    else begin
      if (iss) void'(q.pop_front());
      if (push) q.push_back('{pc, inst});
    end
    @(posedge clk);
    #1;
    if (we && wa != 0) rf[wa] = wd;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    if_valid_i = 0; if_pc_i = 0; if_inst_i = 0; ex_ready_i = 0; wb_we_i = 0;
    wb_addr_i = 0; wb_data_i = 0; resolve_i = 0; flush_i = 0;
    #2 rst = 0;
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_if_ready", if_ready_o, 1);
    chk("rst_pc", pc_o, 0);
    chk("rst_reg1", reg1_o, 0);
    q.delete(); busy = 0; cf = 0; exv = 0; e_wr = 0;
    e_pc = 0; e_r1 = 0; e_r2 = 0; e_imm = 0; e_op = 0; e_f7 = 0; e_f3 = 0; e_wd = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_cycles(input int n);
    logic [31:0] inst;
    logic [4:0] wa;
    bit we;
    int bl[$];
    for (int k = 0; k < n; k++) begin
      inst = $urandom;
      case ($urandom_range(0, 9))
        0: inst[6:0] = 7'h37;
        1: inst[6:0] = 7'h17;
        2: inst[6:0] = 7'h6f;
        3: inst[6:0] = 7'h67;
        4: inst[6:0] = 7'h63;
        5: inst[6:0] = 7'h03;
        6: inst[6:0] = 7'h23;
        7: inst[6:0] = 7'h13;
        8: inst[6:0] = 7'h33;
        default: inst[6:0] = 7'h73;
      endcase
      inst[11:7] = 5'($urandom_range(0, 7));
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      bl.delete();
      for (int r = 1; r < 32; r++) if (busy[r]) bl.push_back(r);
      we = 0; wa = 0;
      if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
        we = 1; wa = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) we = 1;
      cycle($urandom_range(0, 3) != 0, $urandom, inst, $urandom_range(0, 3) != 0, we, wa,
            $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
  endtask
  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 0;
    repeat (2) @(posedge clk);
    do_reset();
    // addi x1,x0,5 then add x2,x1,x1 with writeback of x1 later
    cycle(1, 32'h100, 32'h00500093, 1, 0, 0, 0, 0, 0);
    cycle(1, 32'h104, 32'h00108133, 1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 1, 5'd1, 32'd5, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 1, 5'd2, 32'd10, 0, 0);
    // stalled consumer: six pushes against ex_ready low
    for (int k = 0; k < 6; k++) cycle(1, 32'h200 + 4 * k, 32'h00a00193 + (k << 20), 0, 0, 0, 0, 0, 0);
    idle(6);
    // beq blocks issue until resolve
    cycle(1, 32'h300, 32'h00000063, 1, 0, 0, 0, 0, 0);
    cycle(1, 32'h304, 32'h00700213, 1, 0, 0, 0, 0, 0);
    cycle(1, 32'h308, 32'h00800293, 1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 0, 0, 0, 1, 0);
    idle(3);
    // jal x1 then flush: queued work dropped, x1 stays busy
    cycle(1, 32'h400, 32'h008000ef, 1, 0, 0, 0, 0, 0);
    cycle(1, 32'h404, 32'h00700313, 1, 0, 0, 0, 0, 0);
    cycle(1, 32'h408, 32'h00800393, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 1);
    cycle(1, 32'h500, 32'h001081b3, 1, 0, 0, 0, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 1, 5'd1, 32'h1234, 0, 0);
    idle(2);
    // x0 destinations and sources never stall
    cycle(1, 32'h600, 32'h00100013, 1, 1, 5'd0, 32'hdead, 0, 0);
    cycle(1, 32'h604, 32'h000002b3, 1, 0, 0, 0, 0, 0);
    idle(3);
    rand_cycles(1500);
    for (int k = 0; k < 4; k++) cycle(1, 32'h700 + 4 * k, 32'h00100413, 0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 32'h800, 32'h00000013, 1, 0, 0, 0, 0, 0);
    idle(2);
    rand_cycles(800);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
